// File: rtl/alu_arbiter_if.sv
// Requester, response and shared-ALU signals of alu_arbiter.
// slave = arbiter side, master = requesters plus the combinational ALU.
interface alu_arbiter_if;
  logic        req0, req1;
  logic [2:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, done0, done1;
  logic [63:0] result;
  logic        flagc, flagz, busy;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_operand1, alu_operand2;
  logic [63:0] alu_result;
  logic        alu_flagc, alu_flagz;

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1,
    output gnt0, gnt1, done0, done1, result, flagc, flagz, busy,
    output alu_opcode, alu_operand1, alu_operand2,
    input  alu_result, alu_flagc, alu_flagz
  );

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1,
    input  gnt0, gnt1, done0, done1, result, flagc, flagz, busy,
    input  alu_opcode, alu_operand1, alu_operand2,
    output alu_result, alu_flagc, alu_flagz
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// Build macro ALU_ARB_RR_EN: round-robin on simultaneous requests (default: req0 priority).
module alu_arbiter #(
  parameter int MUL_CYCLES = 2
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for req0/req1; winner picked and latched at the edge
  // EXEC  | latched op/operands drive the ALU for N cycles
  // DONE  | result/flags valid, done pulse to the winner
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam int              N_MUL    = (MUL_CYCLES < 1) ? 1 : MUL_CYCLES;
  localparam int              CW       = (N_MUL > 1) ? $clog2(N_MUL) : 1;
  localparam logic [CW-1:0]   MUL_LAST = CW'(N_MUL - 1);
  localparam logic [2:0]      OP_MUL   = 3'b010;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic          win_q;
  logic [63:0]   result_q;
  logic          flagc_q, flagz_q;
  logic          grant, capture, pick, last_exec;
`ifdef ALU_ARB_RR_EN
  logic          last_q;
`endif

  always_comb begin
    pick = bus.req1;
    if (bus.req0 && bus.req1) begin
`ifdef ALU_ARB_RR_EN
      pick = ~last_q;
`else
      pick = 1'b0;
`endif
    end
  end

  assign last_exec = (op_q != OP_MUL) || (cnt_q == MUL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: if (bus.req0 || bus.req1) begin
        grant   = 1'b1;
        state_d = EXEC;
      end
      EXEC: if (last_exec) begin
        capture = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      win_q    <= 1'b0;
      result_q <= '0;
      flagc_q  <= 1'b0;
      flagz_q  <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_q   <= 1'b1;
`endif
    end else begin
      if (grant) begin
        op_q  <= pick ? bus.op1 : bus.op0;
        a_q   <= pick ? bus.a1  : bus.a0;
        b_q   <= pick ? bus.b1  : bus.b0;
        win_q <= pick;
        cnt_q <= '0;
`ifdef ALU_ARB_RR_EN
        last_q <= pick;
`endif
      end else if (state_q == EXEC && !last_exec) begin
        cnt_q <= cnt_q + CW'(1);
      end
      // carry is only meaningful for add/sub; other opcodes report it clear
      if (capture) begin
        result_q <= bus.alu_result;
        flagz_q  <= bus.alu_flagz;
        flagc_q  <= (op_q == 3'b000 || op_q == 3'b001) ? bus.alu_flagc : 1'b0;
      end
    end
  end

  assign bus.alu_opcode   = op_q;
  assign bus.alu_operand1 = a_q;
  assign bus.alu_operand2 = b_q;

  // cnt_q is zero only in the first EXEC cycle, which makes gnt a single pulse
  assign bus.gnt0  = (state_q == EXEC) && (cnt_q == '0) && !win_q;
  assign bus.gnt1  = (state_q == EXEC) && (cnt_q == '0) &&  win_q;
  assign bus.done0 = (state_q == DONE) && !win_q;
  assign bus.done1 = (state_q == DONE) &&  win_q;
  assign bus.busy  = (state_q != IDLE);

  assign bus.result = result_q;
  assign bus.flagc  = flagc_q;
  assign bus.flagz  = flagz_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: two instances (MUL_CYCLES 3 and 2) with a behavioural ALU each.
// Honours ALU_ARB_RR_EN for the simultaneous-request expectations.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_arbiter_if bus3();
  alu_arbiter_if bus2();

  alu_arbiter #(.MUL_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  alu_arbiter #(.MUL_CYCLES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // carry is deliberately reported high for non add/sub ops so masking is observable
  function automatic logic [65:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] r;
    logic        c;
    case (op)
      3'b000:  begin r = {32'b0, a} + {32'b0, b}; c = r[32]; end
      3'b001:  begin r = {32'b0, a - b}; c = (a < b); end
      3'b010:  begin r = {32'b0, a} * {32'b0, b}; c = 1'b1; end
      3'b011:  begin r = {32'b0, a & b}; c = 1'b1; end
      default: begin r = 64'h0; c = 1'b1; end
    endcase
    return {c, (r == 64'h0), r};
  endfunction

  assign {bus3.alu_flagc, bus3.alu_flagz, bus3.alu_result} =
         alu_model(bus3.alu_opcode, bus3.alu_operand1, bus3.alu_operand2);
  assign {bus2.alu_flagc, bus2.alu_flagz, bus2.alu_result} =
         alu_model(bus2.alu_opcode, bus2.alu_operand1, bus2.alu_operand2);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {bus3.req0, bus3.req1, bus3.op0, bus3.op1} = '0;
    {bus3.a0, bus3.b0, bus3.a1, bus3.b1} = '0;
    {bus2.req0, bus2.req1, bus2.op0, bus2.op1} = '0;
    {bus2.a0, bus2.b0, bus2.a1, bus2.b1} = '0;
    tick();
    tick();
    check("rst_busy", bus3.busy, 1'b0);
    check("rst_gnt", {bus3.gnt0, bus3.gnt1, bus3.done0, bus3.done1}, 4'b0);
    check("rst_result", bus3.result, 64'h0);
    check("rst_alu_op", bus3.alu_opcode, 3'b0);
    rst_n = 1'b1;
    tick();

    // add with carry out
    bus3.req0 = 1'b1; bus3.op0 = 3'b000; bus3.a0 = 32'hFFFF_FFFF; bus3.b0 = 32'h1;
    tick();
    check("add_gnt0", bus3.gnt0, 1'b1);
    check("add_gnt1", bus3.gnt1, 1'b0);
    check("add_busy", bus3.busy, 1'b1);
    check("add_alu_a", bus3.alu_operand1, 32'hFFFF_FFFF);
    bus3.req0 = 1'b0;
    tick();
    check("add_done0", bus3.done0, 1'b1);
    check("add_result", bus3.result, 64'h1_0000_0000);
    check("add_flagc", bus3.flagc, 1'b1);
    check("add_flagz", bus3.flagz, 1'b0);
    tick();
    check("add_idle", {bus3.busy, bus3.done0}, 2'b00);

    // MUL with MUL_CYCLES=3, req0 raised while busy
    bus3.req1 = 1'b1; bus3.op1 = 3'b010; bus3.a1 = 32'h10000; bus3.b1 = 32'h10000;
    tick();
    check("mul_gnt1", {bus3.gnt0, bus3.gnt1}, 2'b01);
    bus3.req1 = 1'b0;
    bus3.req0 = 1'b1; bus3.op0 = 3'b011; bus3.a0 = 32'hF0; bus3.b0 = 32'hF0;
    tick();
    check("mul_c2", {bus3.busy, bus3.done1, bus3.gnt0}, 3'b100);
    tick();
    check("mul_c3", {bus3.busy, bus3.done1, bus3.gnt0}, 3'b100);
    tick();
    check("mul_done1", {bus3.busy, bus3.done1, bus3.done0}, 3'b110);
    check("mul_result", bus3.result, 64'h1_0000_0000);
    check("mul_flagc", bus3.flagc, 1'b0);
    check("mul_flagz", bus3.flagz, 1'b0);
    tick();
    check("busy_ignore_c5", {bus3.busy, bus3.gnt0, bus3.done1}, 3'b000);
    tick();
    check("late_gnt0", bus3.gnt0, 1'b1);
    bus3.req0 = 1'b0;
    tick();
    check("and_done0", bus3.done0, 1'b1);
    check("and_result", bus3.result, 64'hF0);
    check("and_flagc", bus3.flagc, 1'b0);
    tick();

    // operand changes after grant do not disturb the operation
    bus3.req0 = 1'b1; bus3.op0 = 3'b001; bus3.a0 = 32'd5; bus3.b0 = 32'd5;
    tick();
    check("sub_gnt0", bus3.gnt0, 1'b1);
    bus3.req0 = 1'b0; bus3.a0 = 32'd7; bus3.b0 = 32'd2;
    tick();
    check("sub_done0", bus3.done0, 1'b1);
    check("sub_result", bus3.result, 64'h0);
    check("sub_flagz", bus3.flagz, 1'b1);
    check("sub_flagc", bus3.flagc, 1'b0);
    tick();

    // both requesters held high from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus3.req0 = 1'b1; bus3.op0 = 3'b000; bus3.a0 = 32'd1; bus3.b0 = 32'd1;
    bus3.req1 = 1'b1; bus3.op1 = 3'b000; bus3.a1 = 32'd2; bus3.b1 = 32'd2;
    for (int i = 0; i < 4; i++) begin
      logic w;
`ifdef ALU_ARB_RR_EN
      w = i[0];
`else
      w = 1'b0;
`endif
      tick();
      check($sformatf("both_gnt_%0d", i), {bus3.gnt0, bus3.gnt1}, {~w, w});
      tick();
      check($sformatf("both_done_%0d", i), {bus3.done0, bus3.done1}, {~w, w});
      check($sformatf("both_res_%0d", i), bus3.result, w ? 64'd4 : 64'd2);
      if (i == 3) begin
        bus3.req0 = 1'b0;
        bus3.req1 = 1'b0;
      end
      tick();
    end
    tick();
    check("both_end_idle", bus3.busy, 1'b0);

    // MUL_CYCLES=2 instance: load a result, then reset in the middle of EXEC
    bus2.req1 = 1'b1; bus2.op1 = 3'b000; bus2.a1 = 32'd5; bus2.b1 = 32'd6;
    tick();
    bus2.req1 = 1'b0;
    tick();
    check("pre_done1", bus2.done1, 1'b1);
    check("pre_result", bus2.result, 64'hB);
    tick();
    bus2.req0 = 1'b1; bus2.op0 = 3'b010; bus2.a0 = 32'd3; bus2.b0 = 32'd4;
    tick();
    check("rx_gnt0", bus2.gnt0, 1'b1);
    bus2.req0 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rx_busy", bus2.busy, 1'b0);
    check("rx_pulses", {bus2.gnt0, bus2.gnt1, bus2.done0, bus2.done1}, 4'b0);
    check("rx_result", bus2.result, 64'h0);
    check("rx_flags", {bus2.flagc, bus2.flagz}, 2'b00);
    check("rx_alu", {bus2.alu_opcode, bus2.alu_operand1, bus2.alu_operand2}, 67'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rx_no_done_a", bus2.done0, 1'b0);
    tick();
    check("rx_no_done_b", {bus2.done0, bus2.busy}, 2'b00);
    bus2.req1 = 1'b1; bus2.op1 = 3'b011; bus2.a1 = 32'hF0; bus2.b1 = 32'hF0;
    tick();
    check("post_gnt1", {bus2.gnt0, bus2.gnt1}, 2'b01);
    bus2.req1 = 1'b0;
    tick();
    check("post_done1", {bus2.done0, bus2.done1}, 2'b01);
    check("post_result", bus2.result, 64'hF0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 2: cycles held in EXEC for opcode 3'b010 (MUL); values below 1 behave as 1.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0/req1  input  1  request from requester 0/1.
REQ-005 SHALL have ports op0/op1  input  3  opcode of requester 0/1, sampled only at grant.
REQ-006 SHALL have ports a0/b0/a1/b1  input  32  operands of requester 0/1, sampled only at grant.
REQ-007 SHALL have ports gnt0/gnt1  output  1  one-cycle pulse: request accepted and operands latched.
REQ-008 SHALL have ports done0/done1  output  1  one-cycle pulse: result, flagc, flagz valid for that requester.
REQ-009 SHALL have ports result  output  64, flagc  output  1, flagz  output  1  registered response, held until next capture.
REQ-010 SHALL have ports alu_opcode  output  3, alu_operand1/alu_operand2  output  32  drive to the shared combinational ALU.
REQ-011 SHALL have ports alu_result  input  64, alu_flagc/alu_flagz  input  1  returned from the ALU.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE.
REQ-014 IDLE: if req0 or req1 high at an edge, SHALL pick a winner, latch its op/a/b, pulse its gnt next cycle, enter EXEC with cycle counter cleared; otherwise stay IDLE.
REQ-015 alu_opcode/alu_operand1/alu_operand2 SHALL be driven only from the latched registers, never from requester inputs directly.
REQ-016 EXEC SHALL last N cycles: N = MUL_CYCLES for opcode 3'b010, N = 1 for all other opcodes.
REQ-017 At the last EXEC edge SHALL capture alu_result into result, alu_flagz into flagz, and alu_flagc into flagc for opcodes 3'b000/3'b001 only; flagc SHALL be captured as 0 for every other opcode.
REQ-018 DONE SHALL pulse done of the winning requester for exactly one cycle, then return to IDLE.
REQ-019 Latency: winner's gnt high in cycle 1 after the sampling edge, done high in cycle N+1; throughput one operation per N+2 cycles.
REQ-020 Requests arriving while busy SHALL be ignored until IDLE; a requester holding req high after done SHALL be re-arbitrated as a new request.
REQ-021 gnt0/gnt1 and done0/done1 SHALL never be high simultaneously.
REQ-022 Changes on op/a/b of either requester after grant SHALL NOT affect the in-flight operation.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, gnt0/gnt1/done0/done1/busy/flagc/flagz to 0, result to 64'h0, latched op/operands and alu_* outputs to 0, and round-robin pointer to "last = requester 1".
REQ-024 Reset asserted mid-EXEC or mid-DONE SHALL abort the operation with no done pulse; first request after release SHALL be arbitrated normally.

Configuration
REQ-025 With ALU_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the requester not granted last wins; pointer updates at each grant.
REQ-026 Without ALU_ARB_RR_EN, req0 SHALL always win simultaneous requests (fixed priority); single requests are granted identically in both builds.

Verification
REQ-027 req0, op0=000, a0=32'hFFFFFFFF, b0=1 -> gnt0 cycle 1, done0 cycle 2, result=64'h1_0000_0000, flagc=1, flagz=0.
REQ-028 req1, op1=010, a1=32'h10000, b1=32'h10000, MUL_CYCLES=3 -> gnt1 cycle 1, done1 cycle 4, result=64'h1_0000_0000, flagc=0, busy high cycles 1-4.
REQ-029 req0 and req1 held high continuously, RR build -> grants alternate 0,1,0,1 from reset; fixed build -> only gnt0/done0 ever pulse.
REQ-030 req0, op0=001, a0=5, b0=5, operands changed to 7/2 in cycle 1 -> done0 with result=0, flagz=1.
REQ-031 req0 op0=010, MUL_CYCLES=2, rst_n pulsed low in EXEC -> no done0, all outputs 0 at once, next req1 op1=011 a1=b1=32'hF0 -> done1 result=64'hF0.
